// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues one instruction-memory request at a time and queues the returned words for decode.
// Latency: a response sampled at edge M is visible on out_* from cycle M+1 (no bypass); peak rate is one word per 2 cycles.
// Backpressure: a request is issued only while the queue has a free slot; a redirect flushes the queue and drops the in-flight word.
module inst_fetch_queue #(
  parameter logic [63:0] PC_START = 64'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [63:0]   fetch_pc;
  logic [63:0]   req_pc;
  logic [63:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   redirect_tgt;
  logic          req_hs;
  logic          push;
  logic          pop;

  // Fetch addresses are always word aligned.
  assign redirect_tgt   = redirect_pc & ~64'h3;

  // Only request when a slot is guaranteed free for the returning word.
  assign imem_req_valid = !reset && (state == S_REQ) && (count < CW'(QDEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign out_valid      = (count != '0);
  assign out_pc         = out_valid ? q_pc[rd_ptr]   : 64'd0;
  assign out_inst       = out_valid ? q_inst[rd_ptr] : 32'd0;
  assign pop            = out_valid && out_ready;

  // A response is kept only in WAIT and only if no redirect lands in the same cycle.
  assign push           = (state == S_WAIT) && imem_resp_valid && !redirect_valid;

  // Request FSM: REQ issues, WAIT collects, DROP swallows a response made stale by a redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      case (state)
        S_REQ:   if (req_hs) state <= redirect_valid ? S_DROP : S_WAIT;
        S_WAIT:  if (imem_resp_valid) state <= S_REQ;
                 else if (redirect_valid) state <= S_DROP;
        S_DROP:  if (imem_resp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  // Fetch PC advances on each accepted request; a redirect overrides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= PC_START;
      req_pc   <= PC_START;
    end else begin
      if (req_hs) req_pc <= fetch_pc;
      if (redirect_valid) fetch_pc <= redirect_tgt;
      else if (req_hs)    fetch_pc <= fetch_pc + 64'd4;
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue outright.
  always_ff @(posedge clock) begin
    if (reset || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; entries carry the PC the word was fetched from.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= imem_resp_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam logic [63:0] PC0 = 64'h8000_0000;
  localparam int          QD  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_inst = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;

  // Memory environment configuration and state.
  int          mem_lat = 1;
  int          mem_rdy_pct = 100;
  bit          mem_rand_lat = 1'b0;
  bit          mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [63:0] mem_addr = 64'd0;

  // Reference model: queue of {pc, inst}, one outstanding request, keep/discard flag.
  logic [95:0] m_q[$];
  bit          m_busy = 1'b0;
  bit          m_keep = 1'b0;
  logic [63:0] m_pc = PC0;
  logic [63:0] m_req_pc = 64'd0;

  inst_fetch_queue #(.PC_START(PC0), .QDEPTH(QD)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  initial forever #5 clock = ~clock;

  // Advance the model by one clock edge using only the inputs presented to that edge.
  task automatic model_step();
    bit rv, hs, pop, resp;
    if (reset) begin
      m_q.delete(); m_busy = 0; m_keep = 0; m_pc = PC0;
    end else begin
      rv   = !m_busy && (m_q.size() < QD);
      hs   = rv && imem_req_ready;
      pop  = (m_q.size() != 0) && out_ready;
      resp = imem_resp_valid && m_busy;
      if (redirect_valid) begin
        m_q.delete();
        if (resp) m_busy = 0;
        m_keep = 0;
        if (hs) begin m_busy = 1; m_keep = 0; end
        m_pc = {redirect_pc[63:2], 2'b00};
      end else begin
        if (pop) void'(m_q.pop_front());
        if (resp) begin
          if (m_keep) m_q.push_back({m_req_pc, imem_resp_inst});
          m_busy = 0;
        end
        if (hs) begin m_busy = 1; m_keep = 1; m_req_pc = m_pc; m_pc = m_pc + 64'd4; end
      end
    end
  endtask

  // Memory drives at the falling edge, samples handshakes just before the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      imem_resp_valid = 1'b0;
      imem_resp_inst  = 32'd0;
      if (mem_pend) begin
        if (mem_wait <= 1) begin
          imem_resp_valid = 1'b1;
          imem_resp_inst  = ~mem_addr[31:0];
          mem_pend = 1'b0;
        end else mem_wait--;
      end
      imem_req_ready = (mem_rdy_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < mem_rdy_pct);
      #4;
      if (reset) mem_pend = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        mem_pend = 1'b1;
        mem_wait = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        mem_addr = imem_req_addr;
      end
      model_step();
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rst_out_pc got %h exp 0", out_pc); end
    checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL rst_out_inst got %h exp 0", out_inst); end
    @(negedge clock);
    reset = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== PC0) begin errors++; $display("FAIL rel_req_addr got %h exp %h", imem_req_addr, PC0); end
  endtask

  task automatic test_stream();
    bit exp_rv, exp_ov;
    logic [63:0] exp_addr, exp_pc;
    mem_lat = 1; mem_rdy_pct = 100; mem_rand_lat = 0; out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      #2;
      exp_rv   = (c % 2 == 0);
      exp_addr = PC0 + 64'(4 * (c / 2));
      exp_ov   = (c >= 2) && (c % 2 == 0);
      exp_pc   = exp_ov ? PC0 + 64'(4 * (c / 2 - 1)) : 64'd0;
      checks++; if (imem_req_valid !== exp_rv) begin errors++; $display("FAIL stream_req_valid c=%0d got %b exp %b", c, imem_req_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL stream_req_addr c=%0d got %h exp %h", c, imem_req_addr, exp_addr); end
      end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL stream_out_valid c=%0d got %b exp %b", c, out_valid, exp_ov); end
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_out_pc c=%0d got %h exp %h", c, out_pc, exp_pc); end
      if (exp_ov) begin
        checks++; if (out_inst !== ~exp_pc[31:0]) begin errors++; $display("FAIL stream_out_inst c=%0d got %h exp %h", c, out_inst, ~exp_pc[31:0]); end
      end
      @(negedge clock);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [63:0] last;
    mem_lat = 1; mem_rdy_pct = 100; mem_rand_lat = 0; out_ready = 1'b0;
    apply_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (imem_req_valid && imem_req_ready) n++;
      @(negedge clock);
    end
    #2;
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_req_count got %0d exp 2", n); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (out_pc !== PC0) begin errors++; $display("FAIL bp_head_pc got %h exp %h", out_pc, PC0); end
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    n = 0; last = 64'd0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (imem_req_valid && imem_req_ready) begin n++; last = imem_req_addr; end
      @(negedge clock);
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL bp_refill_count got %0d exp 1", n); end
    checks++; if (last !== PC0 + 64'h8) begin errors++; $display("FAIL bp_refill_addr got %h exp %h", last, PC0 + 64'h8); end
  endtask

  task automatic test_redirect_wait();
    int first_idx;
    logic [63:0] first_addr;
    bit got;
    mem_lat = 4; mem_rdy_pct = 100; mem_rand_lat = 0; out_ready = 1'b0;
    apply_reset();
    #2;
    checks++; if (imem_req_addr !== PC0) begin errors++; $display("FAIL rw_first_addr got %h exp %h", imem_req_addr, PC0); end
    @(negedge clock);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    @(negedge clock);
    redirect_valid = 1'b0; mem_lat = 1;
    first_idx = -1; first_addr = 64'd0; got = 0;
    for (int idx = 2; idx < 20; idx++) begin
      #2;
      if (imem_req_valid && first_idx < 0) begin first_idx = idx; first_addr = imem_req_addr; end
      if (out_valid) begin got = 1; break; end
      @(negedge clock);
    end
    checks++; if (first_idx !== 5) begin errors++; $display("FAIL rw_req_cycle got %0d exp 5", first_idx); end
    checks++; if (first_addr !== 64'h8000_0100) begin errors++; $display("FAIL rw_req_addr got %h exp 8000_0100", first_addr); end
    checks++; if (!got) begin errors++; $display("FAIL rw_out_timeout got 0 exp 1"); end
    checks++; if (out_pc !== 64'h8000_0100) begin errors++; $display("FAIL rw_out_pc got %h exp 8000_0100", out_pc); end
    checks++; if (out_inst !== 32'h7fff_feff) begin errors++; $display("FAIL rw_out_inst got %h exp 7ffffeff", out_inst); end
  endtask

  task automatic test_redirect_hs();
    bit found, got;
    logic [63:0] first_addr;
    mem_lat = 1; mem_rdy_pct = 100; mem_rand_lat = 0; out_ready = 1'b1;
    apply_reset();
    found = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (imem_req_valid && imem_req_addr == 64'h8000_0010) begin
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; found = 1; break;
      end
      @(negedge clock);
    end
    checks++; if (!found) begin errors++; $display("FAIL rh_find_req got 0 exp 1"); end
    @(negedge clock);
    redirect_valid = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rh_drop_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_flush_out_valid got %b exp 0", out_valid); end
    first_addr = 64'd0; got = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_req_valid && first_addr == 64'd0) first_addr = imem_req_addr;
      if (out_valid) begin got = 1; break; end
      @(negedge clock);
      #2;
    end
    checks++; if (first_addr !== 64'h8000_0200) begin errors++; $display("FAIL rh_next_addr got %h exp 8000_0200", first_addr); end
    checks++; if (!got || out_pc !== 64'h8000_0200) begin errors++; $display("FAIL rh_out_pc got %h exp 8000_0200", out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_full();
    mem_lat = 1; mem_rdy_pct = 100; mem_rand_lat = 0; out_ready = 1'b0;
    apply_reset();
    repeat (8) @(negedge clock);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rf_full_req_valid got %b exp 0", imem_req_valid); end
    @(negedge clock);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    @(negedge clock);
    out_ready = 1'b0; redirect_valid = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid got %b exp 0", out_valid); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rf_out_pc got %h exp 0", out_pc); end
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rf_req_valid got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h8000_0300) begin errors++; $display("FAIL rf_req_addr got %h exp 8000_0300", imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    bit got;
    mem_lat = 1; mem_rdy_pct = 100; mem_rand_lat = 0; out_ready = 1'b0;
    apply_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req_valid got %b exp 0", imem_req_valid); end
    @(negedge clock);
    reset = 1'b0;
    #2;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== PC0) begin errors++; $display("FAIL rm_restart_addr got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, PC0); end
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin got = 1; break; end
      @(negedge clock);
      #2;
    end
    checks++; if (!got || out_pc !== PC0) begin errors++; $display("FAIL rm_first_out_pc got %h exp %h", out_pc, PC0); end
  endtask

  task automatic test_random();
    bit exp_rv, exp_ov;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    mem_rand_lat = 1; mem_rdy_pct = 70;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset          = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = PC0 + 64'($urandom_range(0, 4095));
      out_ready      = ($urandom_range(0, 2) != 0);
      #2;
      exp_rv   = !reset && !m_busy && (m_q.size() < QD);
      exp_ov   = (m_q.size() != 0);
      exp_pc   = exp_ov ? m_q[0][95:32] : 64'd0;
      exp_inst = exp_ov ? m_q[0][31:0]  : 32'd0;
      checks++; if (imem_req_valid !== exp_rv) begin errors++; $display("FAIL rnd_req_valid i=%0d got %b exp %b", i, imem_req_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (imem_req_addr !== m_pc) begin errors++; $display("FAIL rnd_req_addr i=%0d got %h exp %h", i, imem_req_addr, m_pc); end
      end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid i=%0d got %b exp %b", i, out_valid, exp_ov); end
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL rnd_out_pc i=%0d got %h exp %h", i, out_pc, exp_pc); end
      checks++; if (out_inst !== exp_inst) begin errors++; $display("FAIL rnd_out_inst i=%0d got %h exp %h", i, out_inst, exp_inst); end
    end
    @(negedge clock);
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hs();
    test_redirect_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage sitting directly upstream of instruction decode in the yyang_cpu core. It holds the architectural fetch PC and issues one-at-a-time requests over a valid/ready port to instruction memory, which may have variable latency. Returned instructions go into a small FIFO, and decode consumes them through a valid/ready handshake. A branch/jump redirect from execute flushes the queue and discards any in-flight response.

## Interface
Parameters:
- PC_START, 64'h8000_0000, fetch PC loaded on reset
- QDEPTH, 2, instruction queue entries (power of two, >= 2)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch PC; bits [1:0] ignored (forced to 0)
- imem_req_valid  out  1  fetch request pending
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  fetch address (4-byte aligned)
- imem_resp_valid  in  1  response present; always accepted, no ready
- imem_resp_inst  in  32  returned instruction word
- out_valid  out  1  queue head valid toward decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  64  PC of head entry, 0 when out_valid=0
- out_inst  out  32  instruction of head entry, 0 when out_valid=0

## Operation
- Registers: fetch_pc, FSM state, FIFO of {pc[63:0], inst[31:0]} × QDEPTH, count (0..QDEPTH), rd/wr pointers wrapping modulo QDEPTH.
- At most one request outstanding. FSM states:
  - REQ:
    - imem_req_valid = (count < QDEPTH).
    - On handshake (valid & ready): latch req_pc = fetch_pc, fetch_pc += 4, go to WAIT.
  - WAIT:
    - imem_req_valid = 0.
    - On imem_resp_valid: push {req_pc, imem_resp_inst}, go to REQ.
  - DROP:
    - imem_req_valid = 0.
    - On imem_resp_valid: discard the word, go to REQ.
- Space reservation: a request is issued only when count < QDEPTH. Because of this, a push can never overflow, even with a simultaneous pop.
- Pop on out_valid & out_ready. out_valid = (count != 0). Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1) has highest priority:
  - Queue flushed: count, rd and wr pointers all go to 0. A pop handshake in that cycle counts as completed to the consumer.
  - fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - REQ without handshake → stays REQ. The new address appears next cycle; this is the only case where imem_req_addr may change while valid is pending.
  - REQ with handshake in the same cycle → DROP.
  - WAIT without response → DROP.
  - WAIT with response in the same cycle → the response is discarded, go to REQ.
  - DROP → stays DROP, or goes to REQ if a response arrives that cycle.
- imem_req_addr = fetch_pc. It is held stable while imem_req_valid & !imem_req_ready, except on redirect.
- Memory must not return a response in the same cycle as the request handshake. A response in REQ state is a protocol error and is ignored.

## Timing
- During and after reset:
  - state=REQ, fetch_pc=PC_START, count=0.
  - Outputs: imem_req_valid=0 while reset=1; out_valid=0, out_pc=0, out_inst=0.
- First cycle after reset deasserts: imem_req_valid=1, imem_req_addr=PC_START.
- Latency, with request handshake at edge N:
  - Response is allowed from cycle N+1.
  - If the response is sampled at edge M, out_valid=1 from cycle M+1. There is no bypass.
- Peak throughput: one instruction per 2 cycles (REQ, WAIT with single-cycle memory).
- Redirect takes effect at the next edge. In the following cycle:
  - out_valid=0.
  - imem_req_addr = redirect target if in REQ.
- Queue full (count=QDEPTH): imem_req_valid=0 until a pop. The request may reassert in the cycle after the pop edge.
- Reset mid-operation: returns to the reset state at the next edge. Any pending response is lost, and memory must also be reset.

## Test plan
- Reset release, imem_req_ready=1, response 1 cycle after each handshake, out_ready=1:
  - Request addresses 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - out_pc/out_inst match in order, one every 2 cycles.
- out_ready=0, QDEPTH=2, zero-wait memory:
  - Exactly 2 requests issued, then imem_req_valid=0.
  - Assert out_ready for one cycle → exactly one more request, to 0x8000_0008.
- Redirect to 0x8000_0102 while in WAIT; the stale response arrives 3 cycles later:
  - Stale word never appears on out_*.
  - Next request addr = 0x8000_0100. The first instruction out has out_pc=0x8000_0100.
- Redirect in the same cycle as a request handshake (addr 0x8000_0010):
  - Enters DROP and discards the 0x8000_0010 response.
  - Next request addr = redirect target.
- Redirect while queue is full and out_ready=1:
  - count=0 and out_valid=0 the next cycle.
  - Fetch resumes at target within 1 cycle.
- Reset asserted mid-WAIT:
  - Next cycle out_valid=0 and imem_req_valid=0.
  - After release, the request goes to 0x8000_0000.
